// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared constants and state encoding for the SDRAM arbiter
// Purpose: bus widths, timeout default and FSM state type used by sdram_arb.
// Ports: none (package).
package sdram_arb_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_BUSY = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/sdram_arb_if.sv
// rtl/sdram_arb_if.sv - requester and micro-bus signal bundle for the SDRAM arbiter
// Purpose: groups the two requester ports and the host-controller micro-bus.
// Ports: master = arbiter side (drives gnt/done/rd_data/mp_* strobes),
//        slave  = requesters plus host controller (drive req/wr/addx/wdata, mp_data_in, sdram_busy_l).
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic              rq0_req;
  logic              rq1_req;
  logic              rq0_wr;
  logic              rq1_wr;
  logic [ADDR_W-1:0] rq0_addx;
  logic [ADDR_W-1:0] rq1_addx;
  logic [DATA_W-1:0] rq0_wdata;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq0_gnt;
  logic              rq1_gnt;
  logic              rq0_done;
  logic              rq1_done;
  logic              rq_err;
  logic [DATA_W-1:0] rd_data;
  logic              mp_cs_l;
  logic              mp_rd_l;
  logic              mp_wr_l;
  logic [ADDR_W-1:0] mp_addx;
  logic [DATA_W-1:0] mp_data_out;
  logic [DATA_W-1:0] mp_data_in;
  logic              sdram_busy_l;

  modport master (
    input  rq0_req, rq1_req, rq0_wr, rq1_wr, rq0_addx, rq1_addx,
           rq0_wdata, rq1_wdata, mp_data_in, sdram_busy_l,
    output rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq_err, rd_data,
           mp_cs_l, mp_rd_l, mp_wr_l, mp_addx, mp_data_out
  );

  modport slave (
    output rq0_req, rq1_req, rq0_wr, rq1_wr, rq0_addx, rq1_addx,
           rq0_wdata, rq1_wdata, mp_data_in, sdram_busy_l,
    input  rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq_err, rd_data,
           mp_cs_l, mp_rd_l, mp_wr_l, mp_addx, mp_data_out
  );

endinterface

// File: rtl/sdram_arb_rr_arb2.sv
// rtl/sdram_arb_rr_arb2.sv - two-way round-robin chooser (combinational)
// Purpose: picks one of two requesters, favouring the one not granted last.
// Ports: req[1:0] requests, last = index granted last, sel = chosen index, valid = any request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       valid
);

  // rq1 wins when it is alone, or when both ask and rq0 was served last.
  assign sel   = req[1] & (~req[0] | ~last);
  assign valid = |req;

endmodule

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - two-requester arbiter onto an SDRAM host controller micro-bus
// Purpose: round-robin grants one word cycle at a time, drives cs/rd/wr strobes,
//          waits on sdram_busy_l, aborts on CMD timeout, returns read data.
// Ports: sys_clk, sys_rst_l (sync active-low), bus (sdram_arb_if.master); all outputs registered.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_l,
  sdram_arb_if.master     bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addx_q, addx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cs_l_q, cs_l_d;
  logic              rd_l_q, rd_l_d;
  logic              wr_l_q, wr_l_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic              arb_sel;
  logic              arb_valid;

  rr_arb2 u_rr_arb2 (
    .req   ({bus.rq1_req, bus.rq0_req}),
    .last  (last_gnt_q),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  always_ff @(posedge sys_clk) begin : state_reg
    if (!sys_rst_l) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arb_valid) state_d = S_CMD;
      // Controller acceptance wins over a timeout landing on the same cycle.
      S_CMD: begin
        if (!bus.sdram_busy_l)     state_d = S_BUSY;
        else if (cnt_q == TO_LAST) state_d = S_FIN;
      end
      S_BUSY: if (bus.sdram_busy_l) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addx_d     = addx_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          owner_d        = arb_sel;
          last_gnt_d     = arb_sel;
          wr_d           = arb_sel ? bus.rq1_wr    : bus.rq0_wr;
          addx_d         = arb_sel ? bus.rq1_addx  : bus.rq0_addx;
          wdata_d        = arb_sel ? bus.rq1_wdata : bus.rq0_wdata;
          gnt_d[arb_sel] = 1'b1;
          cnt_d          = '0;
        end
      end
      S_CMD: begin
        if (state_d == S_CMD) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (state_d == S_FIN) begin
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
        end
      end
      S_BUSY: begin
        if (state_d == S_FIN) begin
          done_d[owner_q] = 1'b1;
          if (!wr_q) rd_data_d = bus.mp_data_in;
        end
      end
      default: ;
    endcase
    // Strobes follow the state being entered so they line up with it once registered.
    cs_l_d = !(state_d == S_CMD || state_d == S_BUSY);
    rd_l_d = cs_l_d | wr_d;
    wr_l_d = cs_l_d | ~wr_d;
  end

  always_ff @(posedge sys_clk) begin : datapath_reg
    if (!sys_rst_l) begin
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addx_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      cs_l_q     <= 1'b1;
      rd_l_q     <= 1'b1;
      wr_l_q     <= 1'b1;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addx_q     <= addx_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      cs_l_q     <= cs_l_d;
      rd_l_q     <= rd_l_d;
      wr_l_q     <= wr_l_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rq0_gnt     = gnt_q[0];
  assign bus.rq1_gnt     = gnt_q[1];
  assign bus.rq0_done    = done_q[0];
  assign bus.rq1_done    = done_q[1];
  assign bus.rq_err      = err_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.mp_cs_l     = cs_l_q;
  assign bus.mp_rd_l     = rd_l_q;
  assign bus.mp_wr_l     = wr_l_q;
  assign bus.mp_addx     = addx_q;
  assign bus.mp_data_out = wdata_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - self-checking bench for sdram_arb
module tb_sdram_arb;

  typedef struct {
    logic        owner;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  logic sys_clk;
  logic sys_rst_l;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t done_exp[$];
  logic gnt_exp[$];

  logic hang   = 1'b0;
  int   busy_n = 3;

  sdram_arb_if bus ();

  sdram_arb #(.TIMEOUT(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [15:0] mem_fn(input logic [19:0] a);
    return a[15:0] ^ 16'hA5B5;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(bus.rq0_done || bus.rq1_done) && cyc < 40);
  endtask

  // Host controller model: one cycle after cs_l falls, hold busy_l low for busy_n cycles.
  initial begin
    int   rem   = 0;
    logic armed = 1'b0;
    logic seen  = 1'b0;
    bus.sdram_busy_l = 1'b1;
    bus.mp_data_in   = 16'h0000;
    forever begin
      tick();
      if (!sys_rst_l) begin
        rem = 0; armed = 1'b0; seen = 1'b0;
        bus.sdram_busy_l = 1'b1;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) bus.sdram_busy_l = 1'b1;
        end else if (armed) begin
          armed = 1'b0;
          bus.sdram_busy_l = 1'b0;
          rem = busy_n;
        end else if (!bus.mp_cs_l && !seen && !hang) begin
          armed = 1'b1;
          seen  = 1'b1;
        end
        if (bus.mp_cs_l) seen = 1'b0;
      end
      bus.mp_data_in = mem_fn(bus.mp_addx);
    end
  end

  // Scoreboard: every gnt and done pulse is matched against the expectation queues.
  initial begin
    exp_t e;
    logic g;
    forever begin
      tick();
      if (bus.rq0_gnt || bus.rq1_gnt) begin
        n_checks++;
        if (gnt_exp.size() == 0) begin
          n_fail++;
          $display("FAIL sb_gnt unexpected: got gnt=%b%b required none", bus.rq1_gnt, bus.rq0_gnt);
        end else begin
          g = gnt_exp.pop_front();
          if ({bus.rq1_gnt, bus.rq0_gnt} !== {g, ~g}) begin
            n_fail++;
            $display("FAIL sb_gnt: got gnt=%b%b required %b%b", bus.rq1_gnt, bus.rq0_gnt, g, ~g);
          end
        end
      end
      if (bus.rq0_done || bus.rq1_done) begin
        n_checks++;
        if (done_exp.size() == 0) begin
          n_fail++;
          $display("FAIL sb_done unexpected: got done=%b%b required none", bus.rq1_done, bus.rq0_done);
        end else begin
          e = done_exp.pop_front();
          if ({bus.rq1_done, bus.rq0_done, bus.rq_err, bus.rd_data} !== {e.owner, ~e.owner, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL sb_done: got done=%b%b err=%b rd=%h required done=%b%b err=%b rd=%h",
                     bus.rq1_done, bus.rq0_done, bus.rq_err, bus.rd_data, e.owner, ~e.owner, e.err, e.rd);
          end
        end
      end
    end
  end

  task automatic test_reset();
    sys_rst_l = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 111", {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l});
    end
    n_checks++;
    if (bus.mp_addx !== 20'h0) begin
      n_fail++; $display("FAIL reset_addx: got %h required 00000", bus.mp_addx);
    end
    n_checks++;
    if (bus.mp_data_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_data_out: got %h required 0000", bus.mp_data_out);
    end
    n_checks++;
    if (bus.rd_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h required 0000", bus.rd_data);
    end
    n_checks++;
    if ({bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done, bus.rq_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 00000",
                         {bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done, bus.rq_err});
    end
    sys_rst_l = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int cyc;
    gnt_exp.push_back(1'b0);
    done_exp.push_back('{1'b0, 1'b0, 16'hA5A5});
    bus.rq0_req = 1'b1; bus.rq0_wr = 1'b0; bus.rq0_addx = 20'h00010; bus.rq0_wdata = 16'h0;
    tick();
    n_checks++;
    if ({bus.rq1_gnt, bus.rq0_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL read_gnt: got %b%b required 01", bus.rq1_gnt, bus.rq0_gnt);
    end
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l} !== 3'b001) begin
      n_fail++; $display("FAIL read_strobes: got %b required 001", {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l});
    end
    n_checks++;
    if (bus.mp_addx !== 20'h00010) begin
      n_fail++; $display("FAIL read_addx: got %h required 00010", bus.mp_addx);
    end
    bus.rq0_req = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc + 1 !== 6) begin
      n_fail++; $display("FAIL read_latency: got %0d required 6", cyc + 1);
    end
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l} !== 3'b111) begin
      n_fail++; $display("FAIL read_fin_strobes: got %b required 111", {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l});
    end
    tick();
  endtask

  task automatic test_write();
    int cyc;
    gnt_exp.push_back(1'b1);
    done_exp.push_back('{1'b1, 1'b0, 16'hA5A5});
    bus.rq1_req = 1'b1; bus.rq1_wr = 1'b1; bus.rq1_addx = 20'hFFFFF; bus.rq1_wdata = 16'hBEEF;
    tick();
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l} !== 3'b010) begin
      n_fail++; $display("FAIL write_strobes: got %b required 010", {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l});
    end
    n_checks++;
    if (bus.mp_addx !== 20'hFFFFF) begin
      n_fail++; $display("FAIL write_addx: got %h required fffff", bus.mp_addx);
    end
    n_checks++;
    if (bus.mp_data_out !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_data_out: got %h required beef", bus.mp_data_out);
    end
    bus.rq1_req = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc >= 40) begin
      n_fail++; $display("FAIL write_done_timeout: got %0d cycles required <40", cyc);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int got = 0;
    int budget = 0;
    logic [19:0] a0 = 20'h00100;
    logic [19:0] a1 = 20'h00200;
    for (int k = 0; k < 2; k++) begin
      gnt_exp.push_back(1'b0);
      gnt_exp.push_back(1'b1);
      done_exp.push_back('{1'b0, 1'b0, mem_fn(a0 + 20'(k))});
      done_exp.push_back('{1'b1, 1'b0, mem_fn(a1 + 20'(k))});
    end
    bus.rq0_wr = 1'b0; bus.rq1_wr = 1'b0;
    bus.rq0_addx = a0; bus.rq1_addx = a1;
    bus.rq0_req = 1'b1; bus.rq1_req = 1'b1;
    while (got < 4 && budget < 100) begin
      tick();
      budget++;
      if (bus.rq0_gnt) begin got++; a0 = a0 + 20'd1; bus.rq0_addx = a0; end
      if (bus.rq1_gnt) begin got++; a1 = a1 + 20'd1; bus.rq1_addx = a1; end
      if (got >= 4) begin bus.rq0_req = 1'b0; bus.rq1_req = 1'b0; end
    end
    bus.rq0_req = 1'b0; bus.rq1_req = 1'b0;
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL rr_grants: got %0d required 4", got);
    end
    budget = 0;
    while (done_exp.size() != 0 && budget < 60) begin tick(); budget++; end
    n_checks++;
    if (done_exp.size() != 0) begin
      n_fail++; $display("FAIL rr_drain: got %0d pending required 0", done_exp.size());
    end
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    hang = 1'b1;
    gnt_exp.push_back(1'b0);
    done_exp.push_back('{1'b0, 1'b1, mem_fn(20'h00201)});
    bus.rq0_req = 1'b1; bus.rq0_wr = 1'b0; bus.rq0_addx = 20'h00033;
    tick();
    bus.rq0_req = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL timeout_latency: got %0d required 4", cyc);
    end
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l, bus.rq_err} !== 4'b1111) begin
      n_fail++; $display("FAIL timeout_fin: got strobes/err %b required 1111",
                         {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l, bus.rq_err});
    end
    hang = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    busy_n = 10;
    gnt_exp.push_back(1'b1);
    bus.rq1_req = 1'b1; bus.rq1_wr = 1'b0; bus.rq1_addx = 20'h00044;
    tick();
    bus.rq1_req = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (bus.sdram_busy_l !== 1'b0 || bus.mp_cs_l !== 1'b0) begin
      n_fail++; $display("FAIL midrst_setup: got busy_l=%b cs_l=%b required 0 0", bus.sdram_busy_l, bus.mp_cs_l);
    end
    bus.rq0_req = 1'b1; bus.rq0_wr = 1'b0; bus.rq0_addx = 20'h00055;
    sys_rst_l = 1'b0;
    tick();
    n_checks++;
    if ({bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l} !== 3'b111) begin
      n_fail++; $display("FAIL midrst_strobes: got %b required 111", {bus.mp_cs_l, bus.mp_rd_l, bus.mp_wr_l});
    end
    n_checks++;
    if ({bus.rd_data, bus.mp_addx, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done} !== 40'h0) begin
      n_fail++; $display("FAIL midrst_regs: got rd=%h addx=%h pulses=%b required zeros", bus.rd_data, bus.mp_addx,
                         {bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done});
    end
    busy_n = 3;
    gnt_exp.push_back(1'b0);
    done_exp.push_back('{1'b0, 1'b0, mem_fn(20'h00055)});
    sys_rst_l = 1'b1;
    tick();
    n_checks++;
    if ({bus.rq1_gnt, bus.rq0_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_gnt: got %b%b required 01", bus.rq1_gnt, bus.rq0_gnt);
    end
    bus.rq0_req = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc >= 40) begin
      n_fail++; $display("FAIL midrst_done_timeout: got %0d cycles required <40", cyc);
    end
    tick();
  endtask

  initial begin
    sys_rst_l     = 1'b0;
    bus.rq0_req   = 1'b0; bus.rq1_req   = 1'b0;
    bus.rq0_wr    = 1'b0; bus.rq1_wr    = 1'b0;
    bus.rq0_addx  = '0;   bus.rq1_addx  = '0;
    bus.rq0_wdata = '0;   bus.rq1_wdata = '0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    repeat (3) tick();
    n_checks++;
    if (gnt_exp.size() != 0 || done_exp.size() != 0) begin
      n_fail++; $display("FAIL final_queues: got gnt=%0d done=%0d pending required 0 0", gnt_exp.size(), done_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for the controller to accept a cycle before aborting.
REQ-002 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 sys_rst_l  in  1  reset, synchronous and active-low.
REQ-004 rq0_req, rq1_req  in  1 each  requester wants one SDRAM word cycle; held until gnt.
REQ-005 rq0_wr, rq1_wr  in  1 each  1 = write, 0 = read; valid while req is high.
REQ-006 rq0_addx, rq1_addx  in  20 each  word address.
REQ-007 rq0_wdata, rq1_wdata  in  16 each  write data.
REQ-008 rq0_gnt, rq1_gnt  out  1 each  one-cycle pulse: request accepted and operands latched.
REQ-009 rq0_done, rq1_done  out  1 each  one-cycle pulse: cycle complete.
REQ-010 rq_err  out  1  qualifies done: cycle aborted by timeout.
REQ-011 rd_data  out  16  read data; valid from the done pulse until the next done.
REQ-012 mp_cs_l, mp_rd_l, mp_wr_l  out  1 each  micro-bus strobes to the host controller, active-low.
REQ-013 mp_addx  out  20  latched address.
REQ-014 mp_data_out  out  16  latched write data.
REQ-015 mp_data_in  in  16  read data from the host controller.
REQ-016 sdram_busy_l  in  1  low while the host controller is servicing a cycle.

Function
REQ-017 FSM states and transitions:
- IDLE: exits on any request.
- CMD: strobes asserted; waits for sdram_busy_l low.
- BUSY: waits for sdram_busy_l high.
- FIN: exits to IDLE.
REQ-018 In IDLE, with any req high: set gnt for the chosen requester in the next cycle, latch its addx, wdata and wr, and enter CMD.
REQ-019 Arbitration is round-robin via a last_gnt bit (reset 1, so rq0 wins first); when both requests are high, the requester not granted last wins.
REQ-020 In CMD and BUSY: mp_cs_l=0; mp_rd_l=wr; mp_wr_l=~wr.
REQ-021 CMD→BUSY on the first cycle sdram_busy_l=0.
REQ-022 BUSY→FIN on the first cycle sdram_busy_l=1.
- On that transition, load rd_data from mp_data_in (reads only).
REQ-023 FIN: all strobes high for exactly one cycle; done pulses for the owner with rq_err=0; then go to IDLE.
- Minimum spacing between cycles is 2 strobe-high cycles.
REQ-024 A timeout counter (8-bit) clears on entry to CMD and increments each CMD cycle.
- On reaching TIMEOUT: go to FIN with rq_err=1 and rd_data unchanged.
REQ-025 BUSY has no timeout.
REQ-026 A request arriving in any state other than IDLE waits; no request is lost or granted twice.
REQ-027 A req deasserted after gnt has no effect on the cycle in progress.
REQ-028 sdram_busy_l low while in IDLE is ignored.
REQ-029 Latency: req high in IDLE → strobes low 1 cycle later. A read with a 3-cycle controller busy gives done 6 cycles after req.

Reset
REQ-030 With sys_rst_l low at a clock edge, all of the following are forced on that edge, including mid-cycle:
- state=IDLE
- last_gnt=1
- counter=0
- mp_cs_l/mp_rd_l/mp_wr_l=1
- mp_addx=0, mp_data_out=0, rd_data=0
- gnt/done/rq_err=0
REQ-031 No gnt or done pulse is issued during the first cycle after reset release.

Structure
REQ-032 The shared package holds:
- the state encoding constants;
- the address width (20) and data width (16);
- the TIMEOUT default.
REQ-033 Round-robin choice is one sub-module, rr_arb2, with inputs req[1:0] and last and outputs sel and valid; it is purely combinational.
REQ-034 All outputs are registered.

Verification
REQ-035 rq0 read at addx 0x00010, busy_l low for 3 cycles → mp_rd_l=0; rq0_done after 6 cycles total; rd_data=mp_data_in value 0xA5A5.
REQ-036 rq0 and rq1 request in the same cycle, both held for 4 transactions → grant order 0,1,0,1.
REQ-037 rq1 write 0xBEEF to 0xFFFFF → mp_wr_l=0, mp_addx=0xFFFFF, mp_data_out=0xBEEF; rd_data unchanged.
REQ-038 busy_l held high, TIMEOUT=4 → done with rq_err=1 four cycles after CMD entry; strobes high in FIN.
REQ-039 sys_rst_l low during BUSY → next edge strobes high, state IDLE; a pending req is granted to rq0 after reset release.
